led_fader: RTL and testbench
============================

# led_fader

Per-LED fade/PWM driver downstream of the AXI4-Lite LED register block. It consumes the registered on/off LED vector and ramps each LED's brightness linearly toward full-on or full-off. It drives the pins through a shared free-running PWM, giving glitch-free soft transitions instead of hard switching.

## Interface
- LED_NBR_p, 8, number of LED channels (1..32)
- PWM_BW_p, 8, brightness/duty resolution in bits; MAX = 2^PWM_BW_p-1
- PRESCALE_p, 1024, clk cycles per fade step (>=1)
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_led  in  LED_NBR_p  target per LED: 1 = on, 0 = off (from LED register block)
- o_pwm  out  LED_NBR_p  PWM drive to pins, registered
- o_busy  out  LED_NBR_p  1 while channel is RISING or FALLING
- o_level  out  LED_NBR_p*PWM_BW_p  current linear level per channel, channel i at [i*PWM_BW_p +: PWM_BW_p]

## Operation
- i_led registered once into target register (1-cycle input stage); no other synchronisation.
- Prescaler counts 0..PRESCALE_p-1; tick asserted for one cycle when count == PRESCALE_p-1, then wraps to 0.
- PWM counter counts 0..MAX-1 (period MAX cycles), wraps to 0; wrap cycle = period boundary.
- Per-channel FSM, states OFF, RISING, ON, FALLING:
  - OFF (level 0): target=1 -> RISING.
  - RISING: on tick level+1; on the tick where level becomes MAX -> ON; target=0 -> FALLING (level held, no step that cycle).
  - ON (level MAX): target=0 -> FALLING.
  - FALLING: on tick level-1; on the tick where level becomes 0 -> OFF; target=1 -> RISING.
- Reversal mid-ramp continues from the current level; no jump.
- Duty = f(level), latched into shadow duty register only at the PWM period boundary (no mid-period duty change).
- o_pwm[i] <= (shadow_duty[i] > pwm_cnt). Duty 0: constant 0; duty MAX: constant 1.
- o_busy = state in {RISING, FALLING}, decoded from the state register.
- Full ramp = MAX ticks = MAX*PRESCALE_p cycles.

## Timing
- Reset values: o_pwm 0, o_busy 0, o_level 0, all states OFF, prescaler 0, PWM counter 0, shadow duty 0.
- Reset mid-fade: all levels forced to 0 and outputs to 0 on the reset edge. No ramp-down.
- i_led change at edge N: target updates at N+1; state/o_busy updates at N+2.
- Level step lands on the edge ending the tick cycle; o_level updates the same edge.
- New duty visible on o_pwm from the cycle after the next period boundary: max latency MAX+1 cycles after the level change.
- Target toggled and restored before reaching the FSM (pulse < 1 cycle after input register): no effect. Pulse of exactly 1 cycle in target register: FSM enters RISING/FALLING and returns on the following cycle. Level is unchanged unless a tick coincided.
- Tick coinciding with a state transition: the transition wins; no level step on that edge.

## Configuration
- LED_FADER_GAMMA_EN defined: duty = MAX when level == MAX, else (level*level) >> PWM_BW_p. This gives a perceptual square-law curve; one multiplier per channel.
- Not defined: duty = level (linear); no multiplier.
- o_level is always the linear level in both builds.

## Structure
- Package led_pkg: channel state enum (OFF, RISING, ON, FALLING) and a MAX-level helper function of PWM_BW_p.
- Sub-module led_fader_channel, generated LED_NBR_p times. It holds the FSM, level, gamma mapping and shadow duty, and takes tick, period-boundary and pwm_cnt as inputs.
- Top holds the input register, prescaler and PWM counter, shared by all channels.

## Test plan
Bench config: LED_NBR_p=2, PWM_BW_p=4 (MAX=15), PRESCALE_p=4.
- Reset, i_led=2'b00 for 100 cycles -> o_pwm=0, o_busy=0, o_level=0 throughout.
- i_led 00->01 at edge N -> o_busy[0]=1 from N+2; o_level[3:0] steps 1..15, one step every 4 cycles; o_busy[0]=0 once level=15. After the next period boundary o_pwm[0] is constant 1; channel 1 stays 0.
- Channel 0 at level 8 (linear build) -> o_pwm[0] high exactly 8 of every 15 cycles. With LED_FADER_GAMMA_EN: duty 4 -> high 4 of 15.
- Rising channel at level 6, i_led[0]->0 -> state FALLING. Level continues 6,5,...,0 with no jump, then OFF and o_busy[0]=0.
- rst_n low for 1 cycle with both channels mid-rise -> next edge o_pwm=0, o_level=0, o_busy=0. After release, with i_led still 11, both channels restart rising from 0.
- Level change just after a period boundary -> o_pwm duty unchanged until the following boundary (checked cycle-by-cycle against the reference model).

Source files
------------

// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED fade/PWM driver.
//   - led_state_e   : per-channel ramp state (OFF, RISING, ON, FALLING)
//   - led_max_level : full-scale brightness level for a given bit width
// No ports (package).
// -----------------------------------------------------------------------------
package led_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        RISING  = 2'd1,
        ON      = 2'd2,
        FALLING = 2'd3
    } led_state_e;

    // Full-scale level 2^bw - 1. The 32-bit shift wraps to 0 for bw == 32,
    // so the subtraction still yields all ones in that case.
    function automatic int unsigned led_max_level(input int unsigned bw);
        return (32'd1 << bw) - 32'd1;
    endfunction

endpackage

// File: rtl/led_fader_channel.sv
// -----------------------------------------------------------------------------
// led_fader_channel
// One LED channel. It ramps a linear brightness level toward full-on or
// full-off, one step per prescaler tick. It maps the level to a duty value and
// latches that duty into a shadow register only at PWM period boundaries. It
// then compares the shadow duty against the shared PWM counter to produce a
// registered pin drive.
//
// Optional build macro: LED_FADER_GAMMA_EN
//   defined     : duty = MAX at full level, else (level*level) >> PWM_BW_p
//   not defined : duty = level (linear)
//
// Ports
//   clk, rst_n  : clock, synchronous active-low reset
//   tick        : one-cycle fade step strobe from the shared prescaler
//   period_end  : high on the last cycle of each PWM period
//   pwm_cnt     : shared free-running PWM counter (0..MAX-1)
//   target      : registered request, 1 = on, 0 = off
//   pwm         : registered PWM drive for this LED
//   busy        : high while RISING or FALLING
//   level       : current linear brightness level
// -----------------------------------------------------------------------------
module led_fader_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BW_p = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic                period_end,
    input  logic [PWM_BW_p-1:0] pwm_cnt,
    input  logic                target,
    output logic                pwm,
    output logic                busy,
    output logic [PWM_BW_p-1:0] level
);

    localparam logic [PWM_BW_p-1:0] MAX_LVL = PWM_BW_p'(led_max_level(PWM_BW_p));

    led_state_e          state_q,  state_d;
    logic [PWM_BW_p-1:0] level_q,  level_d;
    logic [PWM_BW_p-1:0] shadow_q, shadow_d;
    logic                pwm_q,    pwm_d;
    logic [PWM_BW_p-1:0] duty;

    // Ramp FSM. A direction change always takes priority over a fade step on
    // the same edge. If the ramp reverses while the level already sits at the
    // new end point, the FSM goes straight to the resting state. This makes a
    // one-cycle target pulse return to where it started, and the level can
    // never wrap.
    always_comb begin
        state_d = state_q;
        level_d = level_q;
        unique case (state_q)
            OFF: begin
                if (target) begin
                    state_d = RISING;
                end
            end
            RISING: begin
                if (!target) begin
                    state_d = (level_q == '0) ? OFF : FALLING;
                end else if (tick) begin
                    level_d = level_q + 1'b1;
                    if (level_q == MAX_LVL - 1'b1) begin
                        state_d = ON;
                    end
                end
            end
            ON: begin
                if (!target) begin
                    state_d = FALLING;
                end
            end
            FALLING: begin
                if (target) begin
                    state_d = (level_q == MAX_LVL) ? ON : RISING;
                end else if (tick) begin
                    level_d = level_q - 1'b1;
                    if (level_q == PWM_BW_p'(1)) begin
                        state_d = OFF;
                    end
                end
            end
            default: begin
                state_d = OFF;
                level_d = '0;
            end
        endcase
    end

`ifdef LED_FADER_GAMMA_EN
    // Square-law perceptual curve. Full level is forced to MAX so the LED is
    // solidly on rather than stopping one step short.
    logic [2*PWM_BW_p-1:0] level_sq;

    always_comb begin
        level_sq = {{PWM_BW_p{1'b0}}, level_q} * {{PWM_BW_p{1'b0}}, level_q};
        duty     = (level_q == MAX_LVL) ? MAX_LVL : level_sq[2*PWM_BW_p-1:PWM_BW_p];
    end
`else
    always_comb begin
        duty = level_q;
    end
`endif

    // The shadow duty only moves at the period boundary, so a period is never
    // cut short or stretched. The pin compare uses the shadow, not the live
    // level.
    always_comb begin
        shadow_d = period_end ? duty : shadow_q;
        pwm_d    = (shadow_q > pwm_cnt);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= OFF;
            level_q  <= '0;
            shadow_q <= '0;
            pwm_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            level_q  <= level_d;
            shadow_q <= shadow_d;
            pwm_q    <= pwm_d;
        end
    end

    assign busy  = (state_q == RISING) || (state_q == FALLING);
    assign level = level_q;
    assign pwm   = pwm_q;

endmodule

// File: rtl/led_fader.sv
// -----------------------------------------------------------------------------
// led_fader
// Per-LED soft fade driver sitting behind the LED register block. It registers
// the on/off request vector once. It runs a shared fade prescaler and a shared
// free-running PWM counter, and instantiates one led_fader_channel per LED.
//
// Optional build macro: LED_FADER_GAMMA_EN (square-law duty mapping inside
// each channel; o_level stays linear either way).
//
// Parameters
//   LED_NBR_p  : number of LED channels (1..32)
//   PWM_BW_p   : level/duty resolution in bits, MAX = 2^PWM_BW_p - 1
//   PRESCALE_p : clk cycles per fade step (>= 1)
// Ports
//   clk, rst_n : clock, synchronous active-low reset
//   i_led      : requested state per LED, 1 = on
//   o_pwm      : registered PWM drive per LED
//   o_busy     : per LED, high while ramping
//   o_level    : linear level, channel i at [i*PWM_BW_p +: PWM_BW_p]
// -----------------------------------------------------------------------------
module led_fader
    import led_pkg::*;
#(
    parameter int unsigned LED_NBR_p  = 8,
    parameter int unsigned PWM_BW_p   = 8,
    parameter int unsigned PRESCALE_p = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [LED_NBR_p-1:0]          i_led,
    output logic [LED_NBR_p-1:0]          o_pwm,
    output logic [LED_NBR_p-1:0]          o_busy,
    output logic [LED_NBR_p*PWM_BW_p-1:0] o_level
);

    localparam logic [PWM_BW_p-1:0] MAX_LVL  = PWM_BW_p'(led_max_level(PWM_BW_p));
    localparam logic [PWM_BW_p-1:0] PWM_LAST = MAX_LVL - 1'b1;
    localparam int unsigned         PS_W     = (PRESCALE_p > 1) ? $clog2(PRESCALE_p) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE_p - 1);

    logic [LED_NBR_p-1:0] target_q,  target_d;
    logic [PS_W-1:0]      presc_q,   presc_d;
    logic [PWM_BW_p-1:0]  pwm_cnt_q, pwm_cnt_d;
    logic                 tick;
    logic                 period_end;

    // Single input stage. The LED register block is in the same clock domain,
    // so no synchroniser is needed.
    always_comb begin
        target_d = i_led;
    end

    // The prescaler and PWM counter both wrap on their own terminal count.
    // The terminal-count cycle is the strobe seen by every channel.
    always_comb begin
        tick       = (presc_q == PS_LAST);
        period_end = (pwm_cnt_q == PWM_LAST);
        presc_d    = tick ? '0 : presc_q + 1'b1;
        pwm_cnt_d  = period_end ? '0 : pwm_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_q  <= '0;
            presc_q   <= '0;
            pwm_cnt_q <= '0;
        end else begin
            target_q  <= target_d;
            presc_q   <= presc_d;
            pwm_cnt_q <= pwm_cnt_d;
        end
    end

    for (genvar i = 0; i < LED_NBR_p; i++) begin : g_chan
        led_fader_channel #(
            .PWM_BW_p (PWM_BW_p)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick       (tick),
            .period_end (period_end),
            .pwm_cnt    (pwm_cnt_q),
            .target     (target_q[i]),
            .pwm        (o_pwm[i]),
            .busy       (o_busy[i]),
            .level      (o_level[i*PWM_BW_p +: PWM_BW_p])
        );
    end

endmodule

// File: tb/tb_led_fader.sv
// -----------------------------------------------------------------------------
// tb_led_fader
// Self-checking bench for led_fader (2 channels, 4-bit levels, prescale 4).
// A behavioural model tracks each channel as a level that is or is not moving
// toward the requested end point. The PWM timing comes from a cycle count since
// reset. Every clock, all outputs are compared against the model.
// -----------------------------------------------------------------------------
module tb_led_fader;

    localparam int NCH  = 2;
    localparam int BW   = 4;
    localparam int PS   = 4;
    localparam int MAXL = 15;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NCH-1:0]      i_led = '0;
    logic [NCH-1:0]      o_pwm;
    logic [NCH-1:0]      o_busy;
    logic [NCH*BW-1:0]   o_level;

    int testsRun = 0;
    int testsFailed = 0;

    // Model state
    int mLevel  [NCH];
    bit mMoving [NCH];
    bit mUp     [NCH];
    bit mTarget [NCH];
    int mShadow [NCH];
    bit mPwm    [NCH];
    int mCyc;

    led_fader #(
        .LED_NBR_p  (NCH),
        .PWM_BW_p   (BW),
        .PRESCALE_p (PS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_led   (i_led),
        .o_pwm   (o_pwm),
        .o_busy  (o_busy),
        .o_level (o_level)
    );

    always #5 clk = ~clk;

    function automatic int dutyOf(input int lvl);
`ifdef LED_FADER_GAMMA_EN
        return (lvl == MAXL) ? MAXL : (lvl * lvl) / (MAXL + 1);
`else
        return lvl;
`endif
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge. All old values are consumed
    // before any of them is overwritten.
    task automatic modelEdge(input logic [NCH-1:0] led, input logic rst);
        bit tick;
        bit boundary;
        int goal;
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                mLevel[i] = 0; mMoving[i] = 0; mUp[i] = 0;
                mTarget[i] = 0; mShadow[i] = 0; mPwm[i] = 0;
            end
            mCyc = 0;
        end else begin
            tick     = (mCyc % PS) == PS - 1;
            boundary = (mCyc % MAXL) == MAXL - 1;
            for (int i = 0; i < NCH; i++) begin
                mPwm[i] = mShadow[i] > (mCyc % MAXL);
                if (boundary) mShadow[i] = dutyOf(mLevel[i]);
                goal = mTarget[i] ? MAXL : 0;
                if (mMoving[i] && (mUp[i] != mTarget[i])) begin
                    mUp[i]     = mTarget[i];
                    mMoving[i] = (mLevel[i] != goal);
                end else if (!mMoving[i] && (mLevel[i] != goal)) begin
                    mMoving[i] = 1;
                    mUp[i]     = mTarget[i];
                end else if (mMoving[i] && tick) begin
                    mLevel[i] = mLevel[i] + (mUp[i] ? 1 : -1);
                    if (mLevel[i] == goal) mMoving[i] = 0;
                end
                mTarget[i] = led[i];
            end
            mCyc++;
        end
    endtask

    // Compare all outputs of all channels against the model.
    task automatic checkOutput();
        for (int i = 0; i < NCH; i++) begin
            checkValue($sformatf("level%0d@%0d", i, mCyc), 32'(o_level[i*BW +: BW]), 32'(mLevel[i]));
            checkValue($sformatf("busy%0d@%0d", i, mCyc), 32'(o_busy[i]), 32'(mMoving[i]));
            checkValue($sformatf("pwm%0d@%0d", i, mCyc), 32'(o_pwm[i]), 32'(mPwm[i]));
        end
    endtask

    // Drive one cycle of inputs, step the model over the edge, then check.
    task automatic applyStimulus(input logic [NCH-1:0] led, input logic rst);
        i_led = led;
        rst_n = rst;
        @(posedge clk);
        modelEdge(led, rst);
        #1;
        checkOutput();
    endtask

    initial begin
        int highs;
        int hold;
        logic [NCH-1:0] led;

        $display("[TB] led_fader bench start");

        // Reset, then idle with LEDs off
        applyStimulus(2'b00, 1'b0);
        applyStimulus(2'b00, 1'b0);
        for (int k = 0; k < 100; k++) applyStimulus(2'b00, 1'b1);
        checkValue("idle_pwm", 32'(o_pwm), 0);
        checkValue("idle_level", 32'(o_level), 0);

        // Channel 0 full rise; busy appears two edges after the input change
        applyStimulus(2'b01, 1'b1);
        checkValue("busy_n1", 32'(o_busy[0]), 0);
        applyStimulus(2'b01, 1'b1);
        checkValue("busy_n2", 32'(o_busy[0]), 1);
        for (int k = 0; k < 200 && !(mLevel[0] == MAXL && !mMoving[0]); k++)
            applyStimulus(2'b01, 1'b1);
        checkValue("rise_done", 32'(o_level[BW-1:0]), MAXL);
        checkValue("rise_idle", 32'(o_busy[0]), 0);
        for (int k = 0; k < 20; k++) applyStimulus(2'b01, 1'b1);
        highs = 0;
        for (int k = 0; k < MAXL; k++) begin
            applyStimulus(2'b01, 1'b1);
            highs += int'(o_pwm[0]);
            checkValue("ch1_quiet", 32'(o_pwm[1]), 0);
        end
        checkValue("full_on_highs", 32'(highs), MAXL);

        // Fall back to off
        for (int k = 0; k < 200 && !(mLevel[0] == 0 && !mMoving[0]); k++)
            applyStimulus(2'b00, 1'b1);
        checkValue("fall_done", 32'(o_level[BW-1:0]), 0);

        // Rise to 8, then toggle every cycle so each edge is a reversal and
        // the level is held; measure the duty over one full period
        for (int k = 0; k < 200 && mLevel[0] != 8; k++) applyStimulus(2'b01, 1'b1);
        highs = 0;
        for (int k = 0; k < 46; k++) begin
            applyStimulus((k % 2 == 0) ? 2'b00 : 2'b01, 1'b1);
            if (k >= 46 - MAXL) highs += int'(o_pwm[0]);
        end
        checkValue("hold_level", 32'(o_level[BW-1:0]), 8);
        checkValue("hold_duty", 32'(highs), 32'(dutyOf(8)));

        // Back to 0, rise to 6, reverse mid-ramp
        for (int k = 0; k < 200 && !(mLevel[0] == 0 && !mMoving[0]); k++)
            applyStimulus(2'b00, 1'b1);
        for (int k = 0; k < 200 && mLevel[0] != 6; k++) applyStimulus(2'b01, 1'b1);
        applyStimulus(2'b00, 1'b1);
        applyStimulus(2'b00, 1'b1);
        checkValue("rev_level", 32'(o_level[BW-1:0]), 6);
        checkValue("rev_busy", 32'(o_busy[0]), 1);
        for (int k = 0; k < 200 && !(mLevel[0] == 0 && !mMoving[0]); k++)
            applyStimulus(2'b00, 1'b1);
        checkValue("rev_off_level", 32'(o_level[BW-1:0]), 0);
        checkValue("rev_off_busy", 32'(o_busy[0]), 0);

        // Reset with both channels mid-rise, then restart from zero
        for (int k = 0; k < 25; k++) applyStimulus(2'b11, 1'b1);
        applyStimulus(2'b11, 1'b0);
        checkValue("rst_pwm", 32'(o_pwm), 0);
        checkValue("rst_level", 32'(o_level), 0);
        checkValue("rst_busy", 32'(o_busy), 0);
        applyStimulus(2'b11, 1'b1);
        applyStimulus(2'b11, 1'b1);
        checkValue("restart_busy", 32'(o_busy), 3);
        for (int k = 0; k < 30; k++) applyStimulus(2'b11, 1'b1);

        // Random request patterns, including single-cycle pulses
        for (int s = 0; s < 60; s++) begin
            led  = 2'($urandom_range(0, 3));
            hold = ($urandom_range(0, 3) == 0) ? 1 : int'($urandom_range(1, 40));
            for (int k = 0; k < hold; k++) applyStimulus(led, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
